// File: rtl/fa_serial_adder.sv
// Bit-serial N-bit adder sequencing the 1-bit full adder FA_cs303, LSB first.
// Define FA_SERIAL_OVF_EN to add the registered signed-overflow output ovf.
//
// state  | meaning
// IDLE   | waiting for start
// ADD    | one operand bit pair per cycle through FA_cs303
// DONE   | one-cycle done pulse, start accepted here as in IDLE

module FA_cs303 (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic C,
    output logic S
);
    assign S = x ^ y ^ z;
    assign C = (x & y) | (z & (x ^ y));
endmodule

module fa_serial_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef FA_SERIAL_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_a_sr;
    logic [N-1:0]    r_b_sr;
    logic [N-1:0]    r_res_sr;
    logic [CW-1:0]   r_cnt;
    logic            r_carry;
    logic            r_busy;
    logic            r_done;
    logic [N-1:0]    r_sum;
    logic            r_cout;
`ifdef FA_SERIAL_OVF_EN
    logic            r_ovf;
`endif

    logic            w_c;
    logic            w_s;
    logic [N-1:0]    w_res_next;

    FA_cs303 u_fa (
        .x (r_a_sr[0]),
        .y (r_b_sr[0]),
        .z (r_carry),
        .C (w_c),
        .S (w_s)
    );

    // S enters at the MSB so after N shifts bit 0 holds the first sum bit
    assign w_res_next = (r_res_sr >> 1) | (N'(w_s) << (N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
`ifdef FA_SERIAL_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_carry  <= cin;
                        r_cnt    <= '0;
                        r_res_sr <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_res_sr <= w_res_next;
                    r_carry  <= w_c;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_sum   <= w_res_next;
                        r_cout  <= w_c;
`ifdef FA_SERIAL_OVF_EN
                        // carry flop here is the carry into the MSB
                        r_ovf   <= r_carry ^ w_c;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef FA_SERIAL_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule
